// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter: command encoding,
// priority encoder and return-stack pointer width.
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_RET,
    CMD_CALL,
    CMD_LOAD,
    CMD_BR,
    CMD_INC
  } pc_cmd_e;

  // Pointer must represent 0..depth inclusive.
  function automatic int sp_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Exactly one command per cycle; lower-priority requests are dropped.
  function automatic pc_cmd_e pc_cmd_encode(
    input logic rst,
    input logic clr_n,
    input logic ret,
    input logic call,
    input logic lp,
    input logic br,
    input logic cp
  );
    if (rst || !clr_n) return CMD_CLR;
    else if (ret)      return CMD_RET;
    else if (call)     return CMD_CALL;
    else if (lp)       return CMD_LOAD;
    else if (br)       return CMD_BR;
    else if (cp)       return CMD_INC;
    else               return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// DEPTH x WIDTH LIFO holding return addresses. The top entry is read
// combinationally so a pop can load the PC in the same cycle it is issued.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic [sp_w(DEPTH)-1:0]   sp,
  output logic                     full,
  output logic                     empty
);

  localparam int SP_W  = sp_w(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [SP_W-1:0]  sp_reg;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx   = IDX_W'(sp_reg);
  assign rd_idx   = IDX_W'(sp_reg - SP_W'(1));
  assign top_data = mem[rd_idx];

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk) begin
    if (clr) begin
      sp_reg <= '0;
    end else if (push) begin
      mem[wr_idx] <= push_data;
      sp_reg      <= sp_reg + SP_W'(1);
    end else if (pop) begin
      sp_reg <= sp_reg - SP_W'(1);
    end
  end

  assign sp    = sp_reg;
  assign full  = (sp_reg == SP_W'(DEPTH));
  assign empty = (sp_reg == '0);

endmodule

// File: rtl/program_counter_stack.sv
// Parametrised PC with relative branch, wrap pulse and optional return stack.
// The return stack (call/ret, sp, full, ovf, unf) exists only with PC_RETURN_STACK_EN.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OFF_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_n,
  input  logic                   cp,
  input  logic                   lp,
  input  logic                   br,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   ep,
  input  logic [WIDTH-1:0]       bus_in,
  input  logic [OFF_W-1:0]       off_in,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_oe,
  output logic [sp_w(DEPTH)-1:0] sp,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
  output logic                   unf,
  output logic                   wrap
);

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_reg;
  logic             ovf_reg;
  logic             unf_reg;
  logic             wrap_reg;
  logic             full_int;
  logic             empty_int;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH+1:0] br_sum;
  logic             br_wrap;

`ifdef PC_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .clr       (cmd == CMD_CLR),
    .push      ((cmd == CMD_CALL) && !full_int),
    .pop       ((cmd == CMD_RET) && !empty_int),
    .push_data (pc_reg + 1'b1),
    .top_data  (top_data),
    .sp        (sp),
    .full      (full_int),
    .empty     (empty_int)
  );
`else
  localparam bit STACK_EN = 1'b0;

  assign top_data  = '0;
  assign full_int  = 1'b0;
  assign empty_int = 1'b1;
  assign sp        = '0;
`endif

  assign cmd = pc_cmd_encode(rst, clr_n, ret & STACK_EN, call & STACK_EN, lp, br, cp);

  // Two guard bits: bit WIDTH flags overflow past the top, bit WIDTH+1 a negative sum.
  assign br_sum  = {2'b00, pc_reg} + {{(WIDTH + 2 - OFF_W){off_in[OFF_W-1]}}, off_in};
  assign br_wrap = br_sum[WIDTH+1] | br_sum[WIDTH];

  always_ff @(posedge clk) begin
    wrap_reg <= 1'b0;
    case (cmd)
      CMD_CLR: begin
        pc_reg  <= '0;
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end
      CMD_RET: begin
        if (!empty_int) pc_reg <= top_data;
        else            unf_reg <= 1'b1;
      end
      CMD_CALL: begin
        if (!full_int) pc_reg <= bus_in;
        else           ovf_reg <= 1'b1;
      end
      CMD_LOAD: pc_reg <= bus_in;
      CMD_BR: begin
        pc_reg   <= br_sum[WIDTH-1:0];
        wrap_reg <= br_wrap;
      end
      CMD_INC: begin
        pc_reg   <= pc_reg + 1'b1;
        wrap_reg <= &pc_reg;
      end
      default: ;
    endcase
  end

  assign pc      = pc_reg;
  assign bus_out = ep ? pc_reg : '0;
  assign bus_oe  = ep;
  assign full    = full_int;
  assign empty   = empty_int;
  assign ovf     = ovf_reg & STACK_EN;
  assign unf     = unf_reg & STACK_EN;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (WIDTH=4, OFF_W=5, DEPTH=4).
// Checks adapt to whether PC_RETURN_STACK_EN is defined.
module tb_program_counter_stack;

  localparam int WIDTH = 4;
  localparam int OFF_W = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, clr_n, cp, lp, br, call, ret, ep;
  logic [WIDTH-1:0] bus_in;
  logic [OFF_W-1:0] off_in;
  logic [WIDTH-1:0] pc, bus_out;
  logic             bus_oe, full, empty, ovf, unf, wrap;
  logic [2:0]       sp;

  int checks = 0;
  int errors = 0;

  program_counter_stack #(.WIDTH(WIDTH), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr_n(clr_n), .cp(cp), .lp(lp), .br(br),
    .call(call), .ret(ret), .ep(ep), .bus_in(bus_in), .off_in(off_in),
    .pc(pc), .bus_out(bus_out), .bus_oe(bus_oe), .sp(sp), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; clr_n = 1; cp = 0; lp = 0; br = 0; call = 0; ret = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk); #1;
    $display("txn %-8s pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b wrap=%b",
             tag, pc, sp, full, empty, ovf, unf, wrap);
  endtask

  task automatic test_reset();
    idle(); rst = 1; ep = 0; bus_in = '0; off_in = '0;
    step("reset");
    rst = 0;
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", sp); end
    checks++; if ({full, empty, ovf, unf, wrap} !== 5'b01000) begin
      errors++; $display("FAIL reset_flags got %b want 01000", {full, empty, ovf, unf, wrap}); end
    checks++; if ({bus_oe, bus_out} !== 5'b0) begin
      errors++; $display("FAIL reset_bus got oe=%b out=%h want 0/0", bus_oe, bus_out); end
  endtask

  task automatic test_count();
    logic [3:0] exp_pc;
    idle(); cp = 1;
    for (int i = 1; i <= 16; i++) begin
      step("inc");
      exp_pc = 4'(i);
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL inc_pc step %0d got %h want %h", i, pc, exp_pc); end
      checks++; if (wrap !== (i == 16)) begin errors++; $display("FAIL inc_wrap step %0d got %b want %b", i, wrap, (i == 16)); end
    end
    idle();
  endtask

  task automatic test_load_branch();
    idle(); lp = 1; bus_in = 4'hA;
    step("load");
    checks++; if (pc !== 4'hA) begin errors++; $display("FAIL load_pc got %h want A", pc); end
    idle(); br = 1; off_in = 5'b11101;  // -3
    step("br");
    checks++; if ({pc, wrap} !== {4'h7, 1'b0}) begin errors++; $display("FAIL br_neg got pc=%h wrap=%b want 7/0", pc, wrap); end
    off_in = 5'b01100;                 // +12: 7+12=19
    step("br");
    checks++; if ({pc, wrap} !== {4'h3, 1'b1}) begin errors++; $display("FAIL br_over got pc=%h wrap=%b want 3/1", pc, wrap); end
    off_in = 5'b11100;                 // -4: 3-4=-1
    step("br");
    checks++; if ({pc, wrap} !== {4'hF, 1'b1}) begin errors++; $display("FAIL br_under got pc=%h wrap=%b want F/1", pc, wrap); end
    idle();
    step("hold");
    checks++; if ({pc, wrap} !== {4'hF, 1'b0}) begin errors++; $display("FAIL hold got pc=%h wrap=%b want F/0", pc, wrap); end
  endtask

  task automatic test_priority();
    logic [3:0] exp_pc;
    idle(); lp = 1; cp = 1; bus_in = 4'h5;
    step("lp+cp");
    checks++; if (pc !== 4'h5) begin errors++; $display("FAIL lp_over_cp got %h want 5", pc); end
    idle(); lp = 1; cp = 1; br = 1; ret = 1; bus_in = 4'hC; off_in = 5'd1;
    step("all");
`ifdef PC_RETURN_STACK_EN
    exp_pc = 4'h5;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL ret_empty_unf got %b want 1", unf); end
`else
    exp_pc = 4'hC;
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL ret_ignored_unf got %b want 0", unf); end
`endif
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL all_cmds_pc got %h want %h", pc, exp_pc); end
    idle(); br = 1; cp = 1; off_in = 5'd2;
    step("br+cp");
    exp_pc = exp_pc + 4'd2;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL br_over_cp got %h want %h", pc, exp_pc); end
    idle(); clr_n = 0; lp = 1; bus_in = 4'h3;
    step("clr");
    checks++; if ({pc, unf, wrap} !== 6'b0) begin errors++; $display("FAIL clr got pc=%h unf=%b wrap=%b want 0/0/0", pc, unf, wrap); end
    idle();
  endtask

`ifdef PC_RETURN_STACK_EN
  task automatic test_call_ret();
    logic [3:0] tgt [5] = '{4'h4, 4'h8, 4'hC, 4'hE, 4'h1};
    logic [3:0] pops [4] = '{4'hD, 4'h9, 4'h5, 4'h4};
    logic [3:0] exp_pc;
    idle(); lp = 1; bus_in = 4'h2;
    step("load");
    idle(); call = 1; bus_in = 4'h9;
    step("call");
    checks++; if ({pc, sp, empty} !== {4'h9, 3'd1, 1'b0}) begin errors++; $display("FAIL call got pc=%h sp=%0d empty=%b want 9/1/0", pc, sp, empty); end
    idle(); ret = 1;
    step("ret");
    checks++; if ({pc, sp, empty} !== {4'h3, 3'd0, 1'b1}) begin errors++; $display("FAIL ret got pc=%h sp=%0d empty=%b want 3/0/1", pc, sp, empty); end
    idle(); call = 1;
    for (int k = 0; k < 5; k++) begin
      bus_in = tgt[k];
      step("call");
      exp_pc = (k < 4) ? tgt[k] : tgt[3];
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL fill_pc call %0d got %h want %h", k, pc, exp_pc); end
      checks++; if ({sp, full, ovf} !== {3'((k < 4) ? k + 1 : 4), (k >= 3), (k == 4)}) begin
        errors++; $display("FAIL fill_flags call %0d got sp=%0d full=%b ovf=%b", k, sp, full, ovf); end
    end
    idle(); ret = 1;
    for (int k = 0; k < 4; k++) begin
      step("ret");
      checks++; if ({pc, sp} !== {pops[k], 3'(3 - k)}) begin errors++; $display("FAIL pop %0d got pc=%h sp=%0d want %h/%0d", k, pc, sp, pops[k], 3 - k); end
    end
    step("ret");
    checks++; if ({pc, unf, empty, ovf} !== {4'h4, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ret_unf got pc=%h unf=%b empty=%b ovf=%b want 4/1/1/1", pc, unf, empty, ovf); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); call = 1;
    for (int k = 0; k < 3; k++) begin
      bus_in = 4'(10 + k);
      step("call");
    end
    checks++; if ({sp, ovf} !== {3'd3, 1'b1}) begin errors++; $display("FAIL mid_state got sp=%0d ovf=%b want 3/1", sp, ovf); end
    rst = 1;
    step("rst");
    checks++; if ({pc, sp, ovf, unf, empty} !== {4'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mid_reset got pc=%h sp=%0d ovf=%b unf=%b empty=%b", pc, sp, ovf, unf, empty); end
    idle();
  endtask
`else
  task automatic test_call_ret();
    idle(); lp = 1; bus_in = 4'h2;
    step("load");
    idle(); call = 1; bus_in = 4'h9;
    step("call");
    checks++; if ({pc, sp, empty, full, ovf} !== {4'h2, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL nostack_call got pc=%h sp=%0d empty=%b full=%b ovf=%b", pc, sp, empty, full, ovf); end
    idle(); ret = 1;
    step("ret");
    checks++; if ({pc, unf} !== {4'h2, 1'b0}) begin errors++; $display("FAIL nostack_ret got pc=%h unf=%b want 2/0", pc, unf); end
    idle(); call = 1; cp = 1;
    step("call+cp");
    checks++; if (pc !== 4'h3) begin errors++; $display("FAIL nostack_call_cp got %h want 3", pc); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); lp = 1; bus_in = 4'h7;
    step("load");
    idle(); rst = 1; cp = 1;
    step("rst");
    checks++; if (pc !== 4'h0) begin errors++; $display("FAIL rst_over_cp got %h want 0", pc); end
    idle();
  endtask
`endif

  task automatic test_bus();
    idle(); lp = 1; bus_in = 4'h6;
    step("load");
    idle(); ep = 1; #1;
    checks++; if ({bus_oe, bus_out} !== {1'b1, 4'h6}) begin errors++; $display("FAIL bus_drive got oe=%b out=%h want 1/6", bus_oe, bus_out); end
    ep = 0; #1;
    checks++; if ({bus_oe, bus_out} !== 5'b0) begin errors++; $display("FAIL bus_idle got oe=%b out=%h want 0/0", bus_oe, bus_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_load_branch();
    test_priority();
    test_call_ret();
    test_reset_mid();
    test_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
